reg_file_neg_sb: RTL
====================

Name: reg_file_neg_sb

Overview:
- Integer register file plus scoreboard for the Core101 pipeline; the read/consume side of negedge-written storage.
- Writeback writes on the falling clock edge. Decode reads combinationally during the rising-edge half, so same-cycle writeback data is visible to decode at the next posedge.
- Per-register busy scoreboard, updated on posedge, produces a decode stall for RAW hazards on in-flight destinations.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH

Ports:
clock_in  in  1  core clock; storage writes on negedge, scoreboard updates on posedge
reset_in  in  1  reset, asynchronous, active-high
rs1_addr_in  in  ADDR_WIDTH  read port 1 index
rs2_addr_in  in  ADDR_WIDTH  read port 2 index
rs1_used_in  in  1  decode instruction reads rs1
rs2_used_in  in  1  decode instruction reads rs2
rs1_data_out  out  DATA_WIDTH  register[rs1_addr_in], combinational
rs2_data_out  out  DATA_WIDTH  register[rs2_addr_in], combinational
wr_en_in  in  1  writeback valid
wr_addr_in  in  ADDR_WIDTH  writeback destination
wr_data_in  in  DATA_WIDTH  writeback value
issue_in  in  1  instruction with destination leaves decode this cycle
issue_rd_in  in  ADDR_WIDTH  destination of issuing instruction
stall_out  out  1  RAW hazard; decode must hold
busy_count_out  out  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset (async, reset_in=1): all registers = 0, all busy bits = 0. Consequently rs*_data_out = 0, stall_out = 0, busy_count_out = 0. Reset mid-operation discards in-flight writes and pending busy bits immediately; no edge is needed.
- Register 0 is hardwired: always reads 0, writes ignored, never busy (issue with rd=0 ignored).
- Write: at negedge clock_in with wr_en_in=1 and wr_addr_in!=0, reg[wr_addr_in] <= wr_data_in. The value appears on the read ports after that negedge, i.e. before the following posedge. There is no posedge write path.
- Reads: purely combinational, no latency beyond the storage update. rs1 == rs2 is legal; both ports return the same value.
- Scoreboard, at posedge, applied per register r!=0:
  - set = issue_in & issue_rd_in==r
  - clr = wr_en_in & wr_addr_in==r
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r])
  - Simultaneous set and clear on the same r: set wins, because the new producer supersedes the old one.
  - Clear on a non-busy r is harmless; the write still occurs.
- Hazard: hz1 = rs1_used_in & busy[rs1_addr_in] & ~(wr_en_in & wr_addr_in==rs1_addr_in); hz2 likewise for rs2.
  - The writeback term is a bypass: the negedge write lands before decode samples at posedge.
  - stall_out = hz1 | hz2, combinational.
  - Address 0 never stalls.
- issue_in is only asserted by decode when stall_out=0. If asserted while stalled, the scoreboard still honours it; the block does not check.
- busy_count_out: registered popcount of busy bits after each posedge update; range 0..NUM_REGS-1.
- No X propagation: unwritten registers read 0 after reset.

Test Plan:
- Reset: load values, assert reset_in mid-cycle (no clock) -> all reads 0, stall_out=0, busy_count_out=0 immediately.
- Negedge write: wr_en=1, addr=5, data=0xDEADBEEF, rs1_addr=5 -> rs1_data_out is old value before the negedge and 0xDEADBEEF after it, before the next posedge.
- x0: write 0x12345678 to addr 0, issue rd=0 -> rs1_data_out(0)=0, busy_count_out stays 0, no stall.
- RAW stall: issue rd=7; next cycle rs2_addr=7, rs2_used=1 -> stall_out=1. Writeback addr 7 data 0x55 that cycle -> stall_out=0 the same cycle (bypass), rs2_data_out=0x55 after the negedge, busy[7]=0 after the posedge.
- Set/clear collision: busy[3]=1; same posedge issue rd=3 and writeback addr=3 -> busy[3] stays 1, busy_count_out unchanged, reg3 holds the written value.
- Unused operand: busy[9]=1, rs1_addr=9, rs1_used=0 -> stall_out=0. Issue rd=1..31 over 31 cycles -> busy_count_out=31.

Source files
------------

// File: rtl/reg_file_neg_sb_if.sv
// Decode/writeback/issue bundle for the Core101 integer register file and scoreboard.
// The master side is the pipeline control that drives the block; the slave side is the block itself.
interface reg_file_neg_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs1_addr_in;
  logic [ADDR_WIDTH-1:0] rs2_addr_in;
  logic                  rs1_used_in;
  logic                  rs2_used_in;
  logic [DATA_WIDTH-1:0] rs1_data_out;
  logic [DATA_WIDTH-1:0] rs2_data_out;
  logic                  wr_en_in;
  logic [ADDR_WIDTH-1:0] wr_addr_in;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  issue_in;
  logic [ADDR_WIDTH-1:0] issue_rd_in;
  logic                  stall_out;
  logic [ADDR_WIDTH:0]   busy_count_out;

  modport master (
    output rs1_addr_in, rs2_addr_in, rs1_used_in, rs2_used_in,
    output wr_en_in, wr_addr_in, wr_data_in, issue_in, issue_rd_in,
    input  rs1_data_out, rs2_data_out, stall_out, busy_count_out
  );

  modport slave (
    input  rs1_addr_in, rs2_addr_in, rs1_used_in, rs2_used_in,
    input  wr_en_in, wr_addr_in, wr_data_in, issue_in, issue_rd_in,
    output rs1_data_out, rs2_data_out, stall_out, busy_count_out
  );
endinterface

// File: rtl/reg_file_neg_sb.sv
// Core101 integer register file written on the falling edge, with a per-register busy
// scoreboard updated on the rising edge that raises a decode stall on RAW hazards.
module reg_file_neg_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  reg_file_neg_sb_if.slave     rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [CNT_W-1:0]      busy_count;
  logic                  wr_nz;
  logic                  hz1;
  logic                  hz2;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] v);
    return (a == '0) ? '0 : v;
  endfunction

  assign wr_nz = rf.wr_en_in & (rf.wr_addr_in != '0);

  // Storage: falling-edge write so decode sees writeback data at the next rising edge.
  always_ff @(negedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_nz) begin
      regs[rf.wr_addr_in] <= rf.wr_data_in;
    end
  end

  assign rf.rs1_data_out = read_port(rf.rs1_addr_in, regs[rf.rs1_addr_in]);
  assign rf.rs2_data_out = read_port(rf.rs2_addr_in, regs[rf.rs2_addr_in]);

  // A new producer on the same register supersedes the retiring one, so set beats clear.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rf.issue_in && (rf.issue_rd_in == ADDR_WIDTH'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (rf.wr_en_in && (rf.wr_addr_in == ADDR_WIDTH'(r))) begin
        busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard: rising-edge update, count registered alongside the busy vector.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= popcount(busy_nxt);
    end
  end

  // busy[0] is never set, so x0 operands cannot stall; a same-cycle writeback bypasses.
  assign hz1 = rf.rs1_used_in & busy[rf.rs1_addr_in]
             & ~(rf.wr_en_in & (rf.wr_addr_in == rf.rs1_addr_in));
  assign hz2 = rf.rs2_used_in & busy[rf.rs2_addr_in]
             & ~(rf.wr_en_in & (rf.wr_addr_in == rf.rs2_addr_in));

  assign rf.stall_out      = hz1 | hz2;
  assign rf.busy_count_out = busy_count;
endmodule
